// File: rtl/region_guard_monitor.sv
// Region guard: checks CPU writes, DMA writes and instruction fetch against programmable and
// fixed protected regions, requests a device reset on violation and keeps a violation record.
module region_guard_monitor #(
   parameter int unsigned       NUM_REGIONS   = 4,
   parameter int unsigned       ADDR_W        = 16,
   parameter logic [ADDR_W-1:0] TCB_BASE      = 16'hA000,
   parameter logic [ADDR_W-1:0] TCB_SIZE      = 16'h4000,
   parameter logic [ADDR_W-1:0] RESET_HANDLER = 16'h0000,
   parameter int unsigned       KILL_HOLD     = 4,
   parameter int unsigned       CNT_W         = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_W-1:0]             pc,
   input  logic [ADDR_W-1:0]             data_addr,
   input  logic                          data_en,
   input  logic [ADDR_W-1:0]             dma_addr,
   input  logic                          dma_en,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_min,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_max,
   input  logic [NUM_REGIONS-1:0]        region_en,
   input  logic [NUM_REGIONS-1:0]        region_xlock,
   output logic                          kill,
   output logic                          viol_valid,
   output logic [3:0]                    viol_region,
   output logic [1:0]                    viol_src,
   output logic [ADDR_W-1:0]             viol_addr,
   output logic [CNT_W-1:0]              viol_count
);

   localparam int unsigned       HoldW    = (KILL_HOLD > 1) ? $clog2(KILL_HOLD) : 1;
   localparam logic [HoldW-1:0]  HoldInit = HoldW'(KILL_HOLD - 1);
   // One extra bit so the exclusive TCB end never wraps.
   localparam logic [ADDR_W:0]   TcbEnd   = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};
   localparam logic [ADDR_W-1:0] MetaLo   = ADDR_W'(16'h0180);
   localparam logic [ADDR_W-1:0] MetaHi   = ADDR_W'(16'h01A5);
   localparam logic [ADDR_W-1:0] LogLo    = ADDR_W'(16'h01B0);
   localparam logic [ADDR_W-1:0] LogHi    = ADDR_W'(16'h0232);
   localparam logic [3:0]        CodeMeta = 4'hE;
   localparam logic [3:0]        CodeLog  = 4'hF;
   localparam logic [1:0]        SrcCpu   = 2'b01;
   localparam logic [1:0]        SrcDma   = 2'b10;
   localparam logic [1:0]        SrcExec  = 2'b11;

   typedef enum logic [0:0] {StRun, StKill} state_e;

   state_e            state_q, state_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic              kill_q, kill_d;
   logic              valid_q, valid_d;
   logic [3:0]        region_q, region_d;
   logic [1:0]        src_q, src_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic                   pc_in_tcb;
   logic                   data_meta, data_log, dma_meta, dma_log;
   logic [NUM_REGIONS-1:0] data_hit, dma_hit, exec_hit;
   logic                   data_viol, dma_viol, exec_viol;
   logic                   viol_any;
   logic [3:0]             win_region;
   logic [1:0]             win_src;
   logic [ADDR_W-1:0]      win_addr;

   // An inverted range (lo > hi) matches nothing.
   function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] hi);
      return (lo <= hi) && (a >= lo) && (a <= hi);
   endfunction

   function automatic logic [3:0] first_region(input logic [NUM_REGIONS-1:0] hits);
      logic [3:0] idx;
      idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hits[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign pc_in_tcb = (pc >= TCB_BASE) && ({1'b0, pc} < TcbEnd);

   assign data_meta = in_range(data_addr, MetaLo, MetaHi);
   assign data_log  = in_range(data_addr, LogLo, LogHi);
   assign dma_meta  = in_range(dma_addr, MetaLo, MetaHi);
   assign dma_log   = in_range(dma_addr, LogLo, LogHi);

   always_comb begin
      data_hit = '0;
      dma_hit  = '0;
      exec_hit = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         data_hit[i] = region_en[i] && in_range(data_addr, region_min[i*ADDR_W +: ADDR_W],
                                                region_max[i*ADDR_W +: ADDR_W]);
         dma_hit[i]  = region_en[i] && in_range(dma_addr, region_min[i*ADDR_W +: ADDR_W],
                                                region_max[i*ADDR_W +: ADDR_W]);
         exec_hit[i] = region_en[i] && region_xlock[i] &&
                       in_range(pc, region_min[i*ADDR_W +: ADDR_W],
                                region_max[i*ADDR_W +: ADDR_W]);
      end
   end

   assign data_viol = data_en && !pc_in_tcb && (data_meta || data_log || (|data_hit));
   assign dma_viol  = dma_en && (dma_meta || dma_log || (|dma_hit));
   assign exec_viol = !pc_in_tcb && (|exec_hit);
   assign viol_any  = data_viol || dma_viol || exec_viol;

   // Source priority CPU > DMA > exec; within a source META > LOG > lowest index.
   always_comb begin
      win_region = '0;
      win_src    = '0;
      win_addr   = '0;
      if (data_viol) begin
         win_src    = SrcCpu;
         win_addr   = data_addr;
         win_region = data_meta ? CodeMeta : (data_log ? CodeLog : first_region(data_hit));
      end else if (dma_viol) begin
         win_src    = SrcDma;
         win_addr   = dma_addr;
         win_region = dma_meta ? CodeMeta : (dma_log ? CodeLog : first_region(dma_hit));
      end else if (exec_viol) begin
         win_src    = SrcExec;
         win_addr   = pc;
         win_region = first_region(exec_hit);
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      valid_d  = 1'b0;
      region_d = region_q;
      src_d    = src_q;
      addr_d   = addr_q;
      count_d  = count_q;
      case (state_q)
         StRun: begin
            hold_d = HoldInit;
            if (viol_any) begin
               state_d  = StKill;
               valid_d  = 1'b1;
               region_d = win_region;
               src_d    = win_src;
               addr_d   = win_addr;
               if (count_q != '1) count_d = count_q + CNT_W'(1);
            end
         end
         StKill: begin
            if (viol_any) begin
               hold_d = HoldInit;
            end else if ((hold_q == '0) && (pc == RESET_HANDLER)) begin
               state_d = StRun;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HoldW'(1);
            end
         end
         default: state_d = StKill;
      endcase
      kill_d = (state_d == StKill);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StKill;
         hold_q   <= HoldInit;
         kill_q   <= 1'b1;
         valid_q  <= 1'b0;
         region_q <= '0;
         src_q    <= '0;
         addr_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         kill_q   <= kill_d;
         valid_q  <= valid_d;
         region_q <= region_d;
         src_q    <= src_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
      end
   end

   assign kill        = kill_q;
   assign viol_valid  = valid_q;
   assign viol_region = region_q;
   assign viol_src    = src_q;
   assign viol_addr   = addr_q;
   assign viol_count  = count_q;

endmodule

// File: tb/tb_region_guard_monitor.sv
// Bench for region_guard_monitor: per-cycle comparison against a behavioural model plus
// directed scenarios with literal expectations.
module tb_region_guard_monitor;

   localparam int NR = 4;
   localparam int KH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   pc, data_addr, dma_addr;
   logic          data_en, dma_en;
   logic [63:0]   region_min, region_max;
   logic [3:0]    region_en, region_xlock;
   logic          kill, viol_valid;
   logic [3:0]    viol_region;
   logic [1:0]    viol_src;
   logic [15:0]   viol_addr;
   logic [7:0]    viol_count;

   int checks = 0;
   int failures = 0;

   region_guard_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .data_addr    (data_addr),
      .data_en      (data_en),
      .dma_addr     (dma_addr),
      .dma_en       (dma_en),
      .region_min   (region_min),
      .region_max   (region_max),
      .region_en    (region_en),
      .region_xlock (region_xlock),
      .kill         (kill),
      .viol_valid   (viol_valid),
      .viol_region  (viol_region),
      .viol_src     (viol_src),
      .viol_addr    (viol_addr),
      .viol_count   (viol_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Behavioural model: returns 14 META, 15 LOG, region index, or -1 for no match.
   function automatic int find_region(input int addr, input bit execute);
      int lo, hi;
      if (!execute && addr >= 'h180 && addr <= 'h1A5) return 14;
      if (!execute && addr >= 'h1B0 && addr <= 'h232) return 15;
      for (int i = 0; i < NR; i++) begin
         lo = int'(region_min[i*16 +: 16]);
         hi = int'(region_max[i*16 +: 16]);
         if (region_en[i] && (!execute || region_xlock[i]) && addr >= lo && addr <= hi)
            return i;
      end
      return -1;
   endfunction

   bit m_ready = 0;
   bit m_kill, m_valid;
   int m_hold, m_region, m_src, m_addr, m_count;
   int w_region, w_src, w_addr, r;
   bit in_tcb;

   always @(posedge clk) begin
      if (reset) begin
         m_ready = 1; m_kill = 1; m_hold = KH - 1; m_valid = 0;
         m_region = 0; m_src = 0; m_addr = 0; m_count = 0;
      end else begin
         in_tcb = (int'(pc) >= 'hA000) && (int'(pc) < 'hA000 + 'h4000);
         w_src = 0; w_region = 0; w_addr = 0;
         r = find_region(int'(data_addr), 0);
         if (data_en && r >= 0 && !in_tcb) begin
            w_src = 1; w_region = r; w_addr = int'(data_addr);
         end else begin
            r = find_region(int'(dma_addr), 0);
            if (dma_en && r >= 0) begin
               w_src = 2; w_region = r; w_addr = int'(dma_addr);
            end else begin
               r = find_region(int'(pc), 1);
               if (r >= 0 && !in_tcb) begin
                  w_src = 3; w_region = r; w_addr = int'(pc);
               end
            end
         end
         m_valid = 0;
         if (!m_kill) begin
            if (w_src != 0) begin
               m_kill = 1; m_valid = 1; m_hold = KH - 1;
               m_region = w_region; m_src = w_src; m_addr = w_addr;
               if (m_count < 255) m_count++;
            end
         end else if (w_src != 0) begin
            m_hold = KH - 1;
         end else if (m_hold == 0 && pc == 16'h0000) begin
            m_kill = 0;
         end else if (m_hold > 0) begin
            m_hold--;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         check("model_kill", 32'(kill), 32'(m_kill));
         check("model_valid", 32'(viol_valid), 32'(m_valid));
         check("model_region", 32'(viol_region), m_region);
         check("model_src", 32'(viol_src), m_src);
         check("model_addr", 32'(viol_addr), m_addr);
         check("model_count", 32'(viol_count), m_count);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_region(input int i, input logic [15:0] lo, input logic [15:0] hi);
      region_min[i*16 +: 16] = lo;
      region_max[i*16 +: 16] = hi;
   endtask

   task automatic recover();
      int n;
      n = 0;
      pc = 16'h0000; data_en = 0; dma_en = 0;
      while (kill && n < 20) begin
         cyc();
         n++;
      end
      check("recover_to_run", 32'(kill), 32'h0);
   endtask

   task automatic one_violation();
      pc = 16'h8000; data_addr = 16'h0190; data_en = 1;
      cyc();
      recover();
   endtask

   task automatic expect_record(input string name, input logic [3:0] reg_e,
                                input logic [1:0] src_e, input logic [15:0] addr_e);
      check({name, "_kill"}, 32'(kill), 32'h1);
      check({name, "_valid"}, 32'(viol_valid), 32'h1);
      check({name, "_region"}, 32'(viol_region), 32'(reg_e));
      check({name, "_src"}, 32'(viol_src), 32'(src_e));
      check({name, "_addr"}, 32'(viol_addr), 32'(addr_e));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; pc = 0; data_addr = 0; data_en = 0; dma_addr = 0; dma_en = 0;
      region_min = '0; region_max = '0; region_en = '0; region_xlock = '0;

      // Reset hold: kill high through the 4th edge, low on the 5th.
      cyc();
      reset = 0;
      check("reset_kill", 32'(kill), 32'h1);
      check("reset_count", 32'(viol_count), 32'h0);
      cyc(); cyc(); cyc();
      check("hold_kill_edge4", 32'(kill), 32'h1);
      cyc();
      check("hold_exit_edge5", 32'(kill), 32'h0);

      // Inclusive upper bound of region 1.
      set_region(1, 16'h4000, 16'h40FF);
      region_en = 4'b0010;
      pc = 16'h8000; data_addr = 16'h40FF; data_en = 1;
      cyc();
      expect_record("cpu_r1", 4'h1, 2'b01, 16'h40FF);
      check("cpu_r1_count", 32'(viol_count), 32'd1);
      data_en = 0;
      cyc();
      check("valid_one_cycle", 32'(viol_valid), 32'h0);
      recover();

      // CPU beats DMA; META reported.
      pc = 16'h8000; data_addr = 16'h0190; data_en = 1; dma_addr = 16'h4010; dma_en = 1;
      cyc();
      expect_record("cpu_meta", 4'hE, 2'b01, 16'h0190);
      recover();

      // TCB exempts CPU writes but not DMA.
      pc = 16'hA100; data_addr = 16'h4010; data_en = 1;
      cyc();
      check("tcb_exempt", 32'(kill), 32'h0);
      dma_addr = 16'h4010; dma_en = 1;
      cyc();
      expect_record("dma_in_tcb", 4'h1, 2'b10, 16'h4010);
      recover();

      // Execute lock, then violations during KILL reload the hold.
      set_region(2, 16'h5000, 16'h5FFF);
      region_en = 4'b0110; region_xlock = 4'b0100;
      pc = 16'h5002;
      cyc();
      expect_record("exec_r2", 4'h2, 2'b11, 16'h5002);
      check("exec_count", 32'(viol_count), 32'd4);
      pc = 16'h0000; data_addr = 16'h0190; data_en = 1;
      cyc(); cyc();
      data_en = 0;
      cyc(); cyc(); cyc();
      check("reload_still_kill", 32'(kill), 32'h1);
      check("kill_no_count", 32'(viol_count), 32'd4);
      check("kill_no_capture", 32'(viol_region), 32'h2);
      cyc();
      check("reload_exit", 32'(kill), 32'h0);

      // Lowest index wins among overlapping regions.
      set_region(0, 16'h4000, 16'h4FFF);
      region_en = 4'b0011; region_xlock = 4'b0000;
      pc = 16'h8000; dma_addr = 16'h4050; dma_en = 1;
      cyc();
      expect_record("dma_low_idx", 4'h0, 2'b10, 16'h4050);
      recover();
      pc = 16'h8000; dma_addr = 16'h0232; dma_en = 1;
      cyc();
      expect_record("dma_log_top", 4'hF, 2'b10, 16'h0232);
      recover();

      // Just outside META/LOG, and TCB edges.
      pc = 16'h8000; data_addr = 16'h01A6; data_en = 1; dma_addr = 16'h0233; dma_en = 1;
      cyc();
      check("outside_meta_log", 32'(kill), 32'h0);
      dma_en = 0; data_addr = 16'h4010; pc = 16'hDFFF;
      cyc();
      check("tcb_last_byte", 32'(kill), 32'h0);
      pc = 16'hE000;
      cyc();
      expect_record("tcb_end", 4'h0, 2'b01, 16'h4010);
      check("count_seven", 32'(viol_count), 32'd7);
      recover();

      // Saturation.
      for (int i = 0; i < 248; i++) one_violation();
      check("count_sat", 32'(viol_count), 32'hFF);
      pc = 16'h8000; data_addr = 16'h01B0; data_en = 1;
      cyc();
      expect_record("sat_extra", 4'hF, 2'b01, 16'h01B0);
      check("count_stays_ff", 32'(viol_count), 32'hFF);

      // Reset in KILL clears record and counter.
      reset = 1; data_en = 0;
      cyc();
      reset = 0;
      check("rst_count", 32'(viol_count), 32'h0);
      check("rst_region", 32'(viol_region), 32'h0);
      check("rst_addr", 32'(viol_addr), 32'h0);
      check("rst_kill", 32'(kill), 32'h1);
      recover();

      // Inverted region matches nothing.
      set_region(3, 16'h6000, 16'h5000);
      region_en = 4'b1000; region_xlock = 4'b1000;
      pc = 16'h5800; data_addr = 16'h5800; data_en = 1; dma_addr = 16'h5800; dma_en = 1;
      cyc(); cyc();
      check("inverted_region", 32'(kill), 32'h0);
      data_en = 0; dma_en = 0; pc = 16'h0000;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
